multibyte_add_seq: RTL and testbench

//  Adds two NBYTES-wide operands over several cycles, one byte per cycle, through an

---
 rtl/multibyte_add_seq_if.sv | 40 ++++
 rtl/multibyte_add_seq.sv | 108 ++++++++++
 tb/tb_multibyte_add_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_if.sv
// Operand/result handshake plus the byte-wide adder connection of the
// multi-byte sequential adder. The slave side is the adder sequencer itself.
// The master side is its environment: the requester, the consumer, and the
// external 8-bit adder.
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // operand request
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  // external byte adder
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  // result delivery
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/multibyte_add_seq.sv
// Sequential W-bit adder (W = 8*NBYTES). It pushes one byte per cycle,
// least significant byte first, through an external 8-bit ripple adder.
// The carry is chained between bytes, so the result equals a single W-bit add.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multibyte_add_seq_if.slave  bus,
  output logic                busy
);

  // Byte index width. It stays at least 1 bit so that NBYTES=1 still has a
  // legal (constant-zero) index register.
  localparam int              IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic [NBYTES-1:0][7:0]   a_q;
  logic [NBYTES-1:0][7:0]   b_q;
  logic [NBYTES-1:0][7:0]   sum_q;
  logic                     cout_q;
  logic                     ovf_q;
  logic                     a_msb;
  logic                     b_msb;

  assign a_msb = a_q[NBYTES-1][7];
  assign b_msb = b_q[NBYTES-1][7];

  // Sequencer: accept operands, walk the bytes through the adder, then hold the result.
  // NOTE: every register here, including the operand and sum byte arrays, is
  // cleared by the async reset. An abort during RUN/DONE therefore leaves no
  // stale partial result visible on out_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. idx, carry and the byte
      // arrays are all read in the same cycle they are updated, and every
      // read must see the value from before the edge.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            carry <= bus.in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= bus.add_sum;
          carry      <= bus.add_cout;
          if (idx == LAST) begin
            cout_q <= bus.add_cout;
            // Signed overflow: operands agree in sign but the top result byte does not.
            ovf_q  <= (a_msb == b_msb) && (bus.add_sum[7] != a_msb);
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder drive and handshake flags, decoded purely from the registered state.
  // NOTE: every output gets a default before the case-like logic, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    if (state == RUN) begin
      bus.add_a   = a_q[idx];
      bus.add_b   = b_q[idx];
      bus.add_cin = carry;
    end
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_sum   = sum_q;
    bus.out_cout  = cout_q;
    bus.out_ovf   = ovf_q;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq. It has a 4-byte instance for the
// directed vectors, the DONE hold and the mid-run reset, and a 1-byte instance
// for the single-cycle case and a run of random back-to-back requests.
// The tb instantiates the external 8-bit adder for each instance as a
// continuous assignment.
module tb_multibyte_add_seq;

  logic clk;
  logic rst_n;
  logic busy4;
  logic busy1;

  int n_tests = 0;
  int n_fail  = 0;

  multibyte_add_seq_if #(.NBYTES(4)) bus4 ();
  multibyte_add_seq_if #(.NBYTES(1)) bus1 ();

  multibyte_add_seq #(.NBYTES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave),
    .busy  (busy4)
  );

  multibyte_add_seq #(.NBYTES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave),
    .busy  (busy1)
  );

  // external 8-bit ripple adders
  assign {bus4.add_cout, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {8'd0, bus4.add_cin};
  assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'd0, bus1.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands to the 4-byte unit, take the accept edge, then wait
  // (bounded) for out_valid. The wait records add_cin for each RUN byte.
  task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output int lat, output logic [3:0] trace);
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_cin   = cin;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat   = 0;
    trace = '0;
    while (!bus4.out_valid && lat < 20) begin
      if (lat < 4) trace[lat] = bus4.add_cin;
      tick();
      lat++;
    end
  endtask

  task automatic release4(input string tag);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus4.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(bus4.in_ready), 64'd1);
  endtask

  task automatic txn4(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [31:0] exp_sum,
                      input logic exp_cout, input logic exp_ovf,
                      output logic [3:0] trace);
    int lat;
    start4(a, b, cin, lat, trace);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(bus4.out_sum), 64'(exp_sum));
    check({tag, "_cout_ovf"}, 64'({bus4.out_cout, bus4.out_ovf}), 64'({exp_cout, exp_ovf}));
    release4(tag);
  endtask

  initial begin
    logic [3:0]  trace;
    logic [31:0] held;
    int          lat;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic [8:0]  full;
    logic        rovf;

    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_a      = '0;
    bus4.in_b      = '0;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_in_ready", 64'(bus4.in_ready), 64'd1);
    check("rst_out_valid_busy", 64'({bus4.out_valid, busy4}), 64'd0);
    check("rst_out_sum", 64'(bus4.out_sum), 64'd0);
    check("rst_cout_ovf", 64'({bus4.out_cout, bus4.out_ovf}), 64'd0);
    check("rst_add_drive", 64'({bus4.add_a, bus4.add_b, bus4.add_cin}), 64'd0);
    rst_n = 1'b1;
    tick();

    // directed 4-byte vectors
    txn4("ff_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, trace);
    txn4("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, trace);
    txn4("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, trace);
    txn4("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, trace);
    check("cin_only_add_cin_trace", 64'(trace), 64'b0001);
    txn4("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0, trace);

    // DONE hold: out_ready low for 10 cycles, in_valid pulses must be ignored
    start4(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, trace);
    check("hold_latency", 64'(lat), 64'd4);
    held = bus4.out_sum;
    check("hold_sum", 64'(held), 64'h0000_0100);
    for (int i = 0; i < 10; i++) begin
      bus4.in_valid = i[0];
      bus4.in_a     = 32'hDEAD_BEEF;
      bus4.in_b     = 32'h0BAD_F00D;
      tick();
      check($sformatf("hold_valid_%0d", i), 64'(bus4.out_valid), 64'd1);
      check($sformatf("hold_stable_%0d", i), 64'(bus4.out_sum), 64'(held));
      check($sformatf("hold_in_ready_%0d", i), 64'(bus4.in_ready), 64'd0);
    end
    bus4.in_valid = 1'b0;
    release4("hold");
    tick();
    check("hold_no_spurious_accept", 64'(busy4), 64'd0);
    check("hold_sum_after", 64'(bus4.out_sum), 64'(held));

    // reset after two RUN cycles
    bus4.in_a     = 32'h1111_1111;
    bus4.in_b     = 32'h2222_2222;
    bus4.in_cin   = 1'b0;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    tick();
    check("pre_abort_busy", 64'(busy4), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", 64'({bus4.in_ready, bus4.out_valid, busy4}), 64'b100);
    check("abort_add_drive", 64'({bus4.add_a, bus4.add_b, bus4.add_cin}), 64'd0);
    check("abort_out_sum", 64'(bus4.out_sum), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    txn4("post_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, trace);

    // single-byte instance: FF + 01
    bus1.in_a     = 8'hFF;
    bus1.in_b     = 8'h01;
    bus1.in_cin   = 1'b0;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check("nb1_run_not_valid", 64'(bus1.out_valid), 64'd0);
    tick();
    check("nb1_latency_valid", 64'(bus1.out_valid), 64'd1);
    check("nb1_result", 64'({bus1.out_ovf, bus1.out_cout, bus1.out_sum}), 64'({1'b0, 1'b1, 8'h00}));
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;

    // single-byte instance: random back-to-back requests vs reference adder
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
      bus1.in_a     = ra;
      bus1.in_b     = rb;
      bus1.in_cin   = rc;
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      tick();
      check($sformatf("rnd_valid_%0d", i), 64'(bus1.out_valid), 64'd1);
      check($sformatf("rnd_result_%0d", i), 64'({bus1.out_ovf, bus1.out_cout, bus1.out_sum}),
            64'({rovf, full[8], full[7:0]}));
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
